// File: rtl/zo_seq_pattern_gen.sv
// rtl/zo_seq_pattern_gen.sv - Moore serial pattern transmitter with 0->1 transition counter
module zo_seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LW-1:0]    len,
    output logic             Y,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [LW-1:0]    edge_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [LW-1:0]    cnt, cnt_n;
    logic [LW-1:0]    edge_n;
    logic [LW-1:0]    len_sat;
    logic             prev_bit, prev_n;
    logic             y_n, valid_n, busy_n, done_n;

    // Requests longer than the shift register send the whole word
    assign len_sat = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;

    // State, datapath and output registers; outputs are registered copies
    // of the next-state decode so every output changes on the same edge
    // as the bit it describes (edge_count stays coherent with Y).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            prev_bit   <= 1'b0;
            edge_count <= '0;
            Y          <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            prev_bit   <= prev_n;
            edge_count <= edge_n;
            Y          <= y_n;
            valid      <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Next-state and next-output decode. cnt is the number of pattern bits
    // still to be shown, including the one currently on Y.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        prev_n  = prev_bit;
        edge_n  = edge_count;
        y_n     = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    // The idle line is 0, so a leading 1 is a transition
                    state_n = SEND;
                    y_n     = data_in[WIDTH-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    prev_n  = data_in[WIDTH-1];
                    edge_n  = data_in[WIDTH-1] ? LW'(1) : '0;
                    sreg_n  = data_in << 1;
                    cnt_n   = len_sat;
                end
            end
            SEND: begin
                if (cnt == LW'(1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    prev_n  = 1'b0;
                end else begin
                    y_n     = sreg[WIDTH-1];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    prev_n  = sreg[WIDTH-1];
                    if (sreg[WIDTH-1] && !prev_bit) begin
                        edge_n = edge_count + LW'(1);
                    end
                    sreg_n  = sreg << 1;
                    cnt_n   = cnt - LW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/zo_seq_pattern_gen.md
Name: zo_seq_pattern_gen

Overview:
Moore-style serial pattern transmitter that drives stimulus into the team's 0-1 sequence Moore detector on its input A.
- Loads a parallel word and shifts it out MSB-first, one bit per clock, with busy/valid/done status.
- Keeps a running count of emitted 0->1 transitions, so the detector's Y pulses can be cross-checked in hardware or in a bench.

Parameters:
WIDTH, 8, max pattern length in bits (>=2)
LW, $clog2(WIDTH+1), width of len and edge_count (derived; do not override)

Ports:
clk  input  1  single system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request to transmit; sampled only in IDLE
data_in  input  WIDTH  pattern, MSB transmitted first
len  input  LW  number of bits to send, counted from the MSB
Y  output  1  serial bit stream (connects to the detector's A)
valid  output  1  high while Y carries a pattern bit
busy  output  1  high in SEND and DONE
done  output  1  one-cycle pulse after the last bit
edge_count  output  LW  count of 0->1 transitions emitted in the current/last pattern

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- All outputs are registered; they are decoded from state and datapath registers only (Moore).
- Reset values: state=IDLE, Y=0, valid=0, busy=0, done=0, edge_count=0, shift reg=0, bit counter=0, prev_bit=0.
- Reset mid-transfer aborts immediately. The next cycle shows reset values, and no done pulse is generated.
- States: IDLE, SEND, DONE.
- IDLE:
  - Y=0 (idle line level), valid=0, busy=0.
  - start=1 with len!=0 accepts the request.
    - Latch data_in.
    - Set cnt = min(len, WIDTH); len>WIDTH saturates to WIDTH.
    - Clear edge_count; prev_bit=0.
    - Next state SEND.
  - start=1 with len=0 is ignored; state stays IDLE.
- Latency: the first bit appears on Y with valid=1 in the cycle after the edge that sampled start.
- SEND, each cycle:
  - Y = current MSB, valid=1.
  - Shift reg shifts left, filling with 0; cnt decrements.
  - If the presented bit=1 and prev_bit=0, edge_count increments in the same register update, so it is coherent with Y.
  - prev_bit is updated to the presented bit.
  - The bit preceding the first bit is the idle 0, so a leading 1 counts as a transition.
  - After the bit with cnt==1 has been presented, next state is DONE.
- DONE: exactly one cycle.
  - done=1, busy=1, valid=0, Y=0.
  - Next state IDLE.
- start is ignored in SEND and DONE; it is not queued. The minimum gap between accepted starts is therefore len+2 cycles.
- edge_count holds its final value from DONE until the next accepted start.
- data_in and len are don't-care except in the cycle start is accepted; later changes do not affect the transfer in flight.
- Maximum edge_count is ceil(WIDTH/2), which fits in LW bits with no overflow.

Test Plan:
- Nominal: reset 2 cycles, then start with data_in=8'b0100_1101, len=8 -> Y=0,1,0,0,1,1,0,1 on the 8 cycles after start, valid=1 throughout; done pulse on the 9th cycle; edge_count=3; detector Y pulses=3.
- Leading one / all ones: data_in=8'hFF, len=8 -> Y=1 for 8 cycles, edge_count=1. Then data_in=8'hAA, len=8 -> Y=1,0,1,0,1,0,1,0, edge_count=4.
- Short and saturated lengths:
  - data_in=8'b1010_0000, len=3 -> Y=1,0,1, done on cycle 4, edge_count=2.
  - len=12 -> exactly 8 bits sent.
  - len=0 -> busy stays 0, no done, edge_count unchanged.
- Ignored start: start held high through SEND and DONE -> no restart mid-pattern. A new transfer begins only after returning to IDLE, with its first bit 2 cycles after done.
- Reset mid-operation: assert reset during the 4th bit of 8'b0100_1101 -> next cycle Y=0, valid=0, busy=0, edge_count=0, done never pulses. A fresh start afterwards transmits normally.
- Data stability: change data_in and len during SEND -> the transmitted sequence is the latched pattern, bit-exact.
